apb4_completer_mem: RTL

//  - Parametrised APB4 completer (slave) backed by a word-addressed register/RAM array.
//  - Adds pstrb byte-lane writes, pprot-based write protection, programmable wait states and pslverr.
//  - Sits on the APB side of the ahb2apb bridge as the reference target for bridge and UVC regressions.

---
 rtl/apb4_pkg.sv | 26 ++
 rtl/apb4_byte_ram.sv | 51 +++++
 rtl/apb4_completer_mem.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 memory-backed completer.
package apb4_pkg;

  // Widest supported data path; per-instance lane math lives in the modules.
  localparam int unsigned MAX_DW    = 64;
  localparam int unsigned MAX_LANES = MAX_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb4_cmp_state_e;

  // Replace each byte lane of old_w with wdata where the strobe is set.
  function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0]    old_w,
                                                   input logic [MAX_DW-1:0]    wdata,
                                                   input logic [MAX_LANES-1:0] strb);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int unsigned b = 0; b < MAX_LANES; b++) begin
      if (strb[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb4_byte_ram.sv
// Word array with a byte-enabled synchronous write port and a registered,
// enable-gated read port whose output holds until the next read.
module apb4_byte_ram
  import apb4_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic            re_i,
  input  logic            rclr_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0]     mem_q [DEPTH];
  logic [DW-1:0]     rdata_q;
  logic [MAX_DW-1:0] merged;
  logic [DW-1:0]     wword;

  // Byte-lane merge of the addressed word with the incoming write data.
  always_comb begin
    merged = strb_merge(MAX_DW'(mem_q[waddr_i]), MAX_DW'(wdata_i), MAX_LANES'(wstrb_i));
    wword  = merged[DW-1:0];
  end

  if (DW < MAX_DW) begin : g_hi_sink
    logic unused_merged_hi;
    assign unused_merged_hi = ^merged[MAX_DW-1:DW];
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wword;
  end

  // Read register: updates only on a read completion, forced to zero on error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb4_completer_mem.sv
// APB4 completer backed by a word array: byte strobes, pprot[0] write
// protection of the low words, programmable wait states and pslverr.
module apb4_completer_mem
  import apb4_pkg::*;
#(
  parameter int unsigned APB_AW     = 32,
  parameter int unsigned APB_DW     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned MAX_WAIT   = 15,
  parameter int unsigned PROT_WORDS = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [APB_AW-1:0]             paddr,
  input  logic [APB_DW-1:0]             pwdata,
  input  logic [APB_DW/8-1:0]           pstrb,
  input  logic [2:0]                    pprot,
  input  logic [$clog2(MAX_WAIT+1)-1:0] wait_cycles,
  output logic [APB_DW-1:0]             prdata,
  output logic                          pready,
  output logic                          pslverr
);

  localparam int unsigned LANES = APB_DW / 8;
  localparam int unsigned OFFW  = $clog2(LANES);
  localparam int unsigned CW    = $clog2(MAX_WAIT + 1);
  localparam int unsigned RAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [APB_AW-1:0] LANE_MASK = APB_AW'(LANES - 1);
  localparam logic [APB_AW-1:0] DEPTH_A   = APB_AW'(DEPTH);
  localparam logic [APB_AW-1:0] PROT_A    = APB_AW'(PROT_WORDS);
  localparam logic [CW-1:0]     MAXW      = CW'(MAX_WAIT);

  apb4_cmp_state_e state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [APB_AW-1:0] addr_q;
  logic              write_q;
  logic [APB_DW-1:0] wdata_q;
  logic [LANES-1:0]  strb_q;
  logic              priv_q;
  logic              pready_q, pslverr_q;

  logic              setup, in_idle, complete, err;
  logic [APB_AW-1:0] cur_addr, idx_full;
  logic              cur_write, cur_priv;
  logic [APB_DW-1:0] cur_wdata;
  logic [LANES-1:0]  cur_strb;
  logic [31:0]       wc_wide;
  logic [CW-1:0]     wc_clamped;
  logic              unused_prot;

  assign setup       = psel & ~penable;
  assign in_idle     = (state_q == IDLE);
  assign unused_prot = ^pprot[2:1];
  assign wc_wide     = 32'(wait_cycles);
  assign wc_clamped  = (wc_wide > MAX_WAIT) ? MAXW : wait_cycles;

  // A zero-wait access completes on its SETUP edge, before the latched copy
  // exists, so IDLE decodes the live bus and other states the latched copy.
  always_comb begin
    cur_addr  = in_idle ? paddr    : addr_q;
    cur_write = in_idle ? pwrite   : write_q;
    cur_wdata = in_idle ? pwdata   : wdata_q;
    cur_strb  = in_idle ? pstrb    : strb_q;
    cur_priv  = in_idle ? pprot[0] : priv_q;
  end

  // Address decode and error classification.
  always_comb begin
    idx_full = cur_addr >> OFFW;
    err = (idx_full >= DEPTH_A)
        | ((cur_addr & LANE_MASK) != '0)
        | (cur_write & (idx_full < PROT_A) & ~cur_priv);
  end

  // Next-state logic; complete marks the edge that raises pready.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          cnt_d = wc_clamped;
          if (wc_clamped == '0) begin
            state_d  = DONE;
            complete = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          if (cnt_q <= CW'(1)) begin
            state_d  = DONE;
            cnt_d    = '0;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, wait counter and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= complete;
      pslverr_q <= complete & err;
    end
  end

  // Transfer attributes captured in SETUP; later bus changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      priv_q  <= 1'b0;
    end else if (in_idle && setup) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      priv_q  <= pprot[0];
    end
  end

  apb4_byte_ram #(
    .DW    (APB_DW),
    .DEPTH (DEPTH),
    .AW    (RAW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .we_i    (complete & cur_write & ~err),
    .waddr_i (idx_full[RAW-1:0]),
    .wdata_i (cur_wdata),
    .wstrb_i (cur_strb),
    .re_i    (complete & ~cur_write),
    .rclr_i  (err),
    .raddr_i (idx_full[RAW-1:0]),
    .rdata_o (prdata)
  );

  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
